// File: rtl/hue_to_note.sv
// rtl/hue_to_note.sv - hue to octave-position inverse mapping, 4-stage pipeline; define HUE2NOTE_ROUND_EN for round-half-up scaling
module hue_to_note #(
  parameter int D         = 10,
  parameter int HueYellow = 170,
  parameter int HueBlue   = 682,
  parameter int PosRed    = 341,
  parameter int PosBlue   = 683,
  parameter int K0        = 131200,
  parameter int K1        = 65600,
  parameter int K2        = 43691
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [D-1:0] hue_i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [D-1:0] notePosition_o,
  output logic         out_valid,
  input  logic         out_ready
);

  // product width: D-bit delta times an 18-bit Q2.16 slope
  localparam int PW = D + 18;

  localparam logic [D-1:0]  HUE_Y      = D'(HueYellow);
  localparam logic [D-1:0]  HUE_B      = D'(HueBlue);
  localparam logic [PW-1:0] POS_RED_W  = PW'(PosRed);
  localparam logic [PW-1:0] POS_BLUE_W = PW'(PosBlue);
  localparam logic [PW-1:0] K0_W       = PW'(K0);
  localparam logic [PW-1:0] K1_W       = PW'(K1);
  localparam logic [PW-1:0] K2_W       = PW'(K2);
`ifdef HUE2NOTE_ROUND_EN
  localparam logic [PW-1:0] RND        = PW'(32768);
`else
  localparam logic [PW-1:0] RND        = PW'(0);
`endif

  typedef enum logic [1:0] {
    SEG0 = 2'd0,
    SEG1 = 2'd1,
    SEG2 = 2'd2
  } seg_t;

  logic          advance;
  logic          s1_valid, s2_valid, s3_valid;
  logic [D-1:0]  s1_hue;
  seg_t          seg_d, s2_seg, s3_seg;
  logic [D-1:0]  delta_d, s2_delta;
  logic [PW-1:0] k_sel, s3_prod, frac_w;
  logic [D-1:0]  pos_d;

  // whole pipe moves together; any stall at the output freezes every stage
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // valid bits and the visible output register carry the reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid       <= 1'b0;
      s2_valid       <= 1'b0;
      s3_valid       <= 1'b0;
      out_valid      <= 1'b0;
      notePosition_o <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      if (s3_valid) notePosition_o <= pos_d;
    end
  end

  // pipe data registers only need to follow the valids, so no reset
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_hue   <= hue_i;
      s2_delta <= delta_d;
      s2_seg   <= seg_d;
      s3_prod  <= PW'(s2_delta) * k_sel;
      s3_seg   <= s2_seg;
    end
  end

  // segment choice and distance from the segment's anchor hue
  always_comb begin
    seg_d   = SEG0;
    delta_d = s1_hue;
    if (s1_hue <= HUE_Y) begin
      seg_d   = SEG0;
      delta_d = s1_hue;
    end else if (s1_hue <= HUE_B) begin
      seg_d   = SEG2;
      delta_d = HUE_B - s1_hue;
    end else begin
      seg_d   = SEG1;
      delta_d = {D{1'b0}} - s1_hue;
    end
  end

  // slope for the segment held in stage 2
  always_comb begin
    k_sel = K2_W;
    case (s2_seg)
      SEG0:    k_sel = K0_W;
      SEG1:    k_sel = K1_W;
      default: k_sel = K2_W;
    endcase
  end

  // drop the Q16 fraction and offset from the anchor note; result wraps mod 2^D
  always_comb begin
    frac_w = (s3_prod + RND) >> 16;
    pos_d  = D'(POS_BLUE_W + frac_w);
    case (s3_seg)
      SEG0:    pos_d = D'(POS_RED_W - frac_w);
      SEG1:    pos_d = D'(POS_RED_W + frac_w);
      default: pos_d = D'(POS_BLUE_W + frac_w);
    endcase
  end

endmodule

// File: tb/tb_hue_to_note.sv
// tb/tb_hue_to_note.sv - directed bench for hue_to_note (both HUE2NOTE_ROUND_EN builds)
module tb_hue_to_note;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] hue_i = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] notePosition_o;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

`ifdef HUE2NOTE_ROUND_EN
  localparam logic [9:0] E171 = 10'd0;
`else
  localparam logic [9:0] E171 = 10'd1023;
`endif

  logic [9:0] s_hue [7];
  logic [9:0] s_exp [7];

  always #5 clk = ~clk;

  hue_to_note dut (
    .clk(clk),
    .rst(rst),
    .hue_i(hue_i),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .notePosition_o(notePosition_o),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one isolated item: output must be absent for 3 cycles, present on the 4th
  task automatic single(input logic [9:0] h, input logic [9:0] e, input string tag);
    @(negedge clk);
    hue_i = h; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pos"}, 32'(notePosition_o), 32'(e));
  endtask

  // stream n items; out_ready is low for cycles st0..st1-1
  task automatic stream(input int n, input int st0, input int st1, input string tag);
    int tx = 0;
    int rx = 0;
    for (int t = 0; t < n + 12; t++) begin
      @(negedge clk);
      out_ready = !(t >= st0 && t < st1);
      if (tx < n) begin
        hue_i = s_hue[tx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (st1 <= st0)
        chk({tag, "_timing"}, 32'(out_valid), 32'(t >= 4 && t < n + 4));
      if (out_valid && out_ready) begin
        if (rx < n) chk({tag, "_pos"}, 32'(notePosition_o), 32'(s_exp[rx]));
        rx++;
      end else if (out_valid) begin
        chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        if (rx < n) chk({tag, "_hold"}, 32'(notePosition_o), 32'(s_exp[rx]));
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, 32'(rx), 32'(n));
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pos", 32'(notePosition_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // anchors, boundaries and wrap
    single(10'd0,    10'd341, "h0");
    single(10'd682,  10'd683, "h682");
    single(10'd1023, 10'd342, "h1023");
    single(10'd170,  10'd1,   "h170");
    single(10'd512,  10'd796, "h512");
    single(10'd171,  E171,    "h171");
    single(10'd683,  10'd682, "h683");
    single(10'd1,    10'd339, "h1");

    s_hue[0] = 10'd0;    s_exp[0] = 10'd341;
    s_hue[1] = 10'd170;  s_exp[1] = 10'd1;
    s_hue[2] = 10'd171;  s_exp[2] = E171;
    s_hue[3] = 10'd512;  s_exp[3] = 10'd796;
    s_hue[4] = 10'd682;  s_exp[4] = 10'd683;
    s_hue[5] = 10'd683;  s_exp[5] = 10'd682;
    s_hue[6] = 10'd1023; s_exp[6] = 10'd342;

    // back-to-back, no stall
    stream(7, 0, 0, "stream");
    // 3-cycle backpressure mid-stream
    stream(7, 6, 9, "stall");

    // reset with three items in flight, one parked at the output
    @(negedge clk);
    out_ready = 1'b0;
    hue_i = 10'd0; in_valid = 1'b1;
    @(negedge clk);
    hue_i = 10'd682;
    @(negedge clk);
    hue_i = 10'd1023;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_pos", 32'(notePosition_o), 32'd341);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_pos", 32'(notePosition_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    single(10'd512, 10'd796, "post_rst");
    @(negedge clk);
    #1 chk("post_rst_drain", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
